reaction_delay_timer: RTL

Consumer stage for the 4-bit LFSR random source. On a start pulse it captures the random value `count_rnd` (2..15) as a delay in units, waits that many units with the stimulus LED dark, lights the LED, then measures the user's reaction time in ticks until a button press. It also reports a press made before the LED lit. It sits between the LFSR and the display/score logic of the reaction-time game.

---
 rtl/reaction_delay_timer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/reaction_delay_timer.sv
// reaction_delay_timer
// Trial sequencer for the reaction-time game. A start pulse captures a random
// delay (in units), keeps the LED dark for that long, lights it, and then
// counts ticks until the user presses the button. Presses made while the LED
// is still dark are flagged as early. If the reaction counter fills up with no
// press, the trial ends with a timeout.

module reaction_delay_timer #(
    parameter int TICK_DIV   = 100_000,
    parameter int UNIT_TICKS = 250,
    parameter int RT_W       = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            btn,
    input  logic [3:0]      count_rnd,
    output logic            led,
    output logic            busy,
    output logic            done,
    output logic            early,
    output logic            timeout,
    output logic [RT_W-1:0] rt,
    output logic [3:0]      delay_used
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int UW = (UNIT_TICKS > 1) ? $clog2(UNIT_TICKS) : 1;

    localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [UW-1:0]   UNIT_LAST  = UW'(UNIT_TICKS - 1);
    localparam logic [RT_W-1:0] RT_MAX     = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DELAY = 2'd1,
        S_ARMED = 2'd2
    } state_t;

    state_t          r_state, w_state_next;
    logic [PW-1:0]   r_presc, w_presc_next;
    logic [UW-1:0]   r_tiu, w_tiu_next;      // ticks within the current unit
    logic [3:0]      r_unit, w_unit_next;    // whole units elapsed in DELAY
    logic [3:0]      r_delay, w_delay_next;
    logic [RT_W-1:0] r_rt, w_rt_next;
    logic            r_done, w_done_next;
    logic            r_early, w_early_next;
    logic            r_timeout, w_timeout_next;
    logic            r_led, r_busy;

    logic            w_tick;
    logic [RT_W-1:0] w_rt_inc;

    assign w_tick   = (r_presc == PRESC_LAST);
    // A tick that coincides with a press is counted before the press freezes rt.
    assign w_rt_inc = (w_tick && (r_rt != RT_MAX)) ? r_rt + 1'b1 : r_rt;

    // Next-state and next-datapath decode for the trial sequencer.
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement leaves a value unassigned and no latch is inferred.
    always_comb begin
        w_state_next   = r_state;
        w_presc_next   = w_tick ? '0 : r_presc + 1'b1;
        w_tiu_next     = r_tiu;
        w_unit_next    = r_unit;
        w_delay_next   = r_delay;
        w_rt_next      = r_rt;
        w_done_next    = r_done;
        w_early_next   = r_early;
        w_timeout_next = r_timeout;

        case (r_state)
            S_IDLE: begin
                // start beats a simultaneous btn; a lone btn is ignored
                if (start) begin
                    w_state_next   = S_DELAY;
                    w_delay_next   = (count_rnd < 4'd2) ? 4'd2 : count_rnd;
                    w_rt_next      = '0;
                    w_done_next    = 1'b0;
                    w_early_next   = 1'b0;
                    w_timeout_next = 1'b0;
                    w_presc_next   = '0;
                    w_tiu_next     = '0;
                    w_unit_next    = '0;
                end
            end

            S_DELAY: begin
                if (btn) begin
                    w_state_next = S_IDLE;
                    w_early_next = 1'b1;
                    w_rt_next    = '0;
                end else if (w_tick) begin
                    if (r_tiu == UNIT_LAST) begin
                        w_tiu_next  = '0;
                        w_unit_next = r_unit + 4'd1;
                        // Arm on the same edge the last unit completes.
                        if (r_unit + 4'd1 == r_delay) begin
                            w_state_next = S_ARMED;
                            w_presc_next = '0;
                        end
                    end else begin
                        w_tiu_next = r_tiu + 1'b1;
                    end
                end
            end

            S_ARMED: begin
                w_rt_next = w_rt_inc;
                if (btn) begin
                    w_state_next = S_IDLE;
                    w_done_next  = 1'b1;
                end else if (w_rt_inc == RT_MAX) begin
                    w_state_next   = S_IDLE;
                    w_done_next    = 1'b1;
                    w_timeout_next = 1'b1;
                end
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_presc   <= '0;
            r_tiu     <= '0;
            r_unit    <= '0;
            r_delay   <= '0;
            r_rt      <= '0;
            r_done    <= 1'b0;
            r_early   <= 1'b0;
            r_timeout <= 1'b0;
            r_led     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_presc   <= w_presc_next;
            r_tiu     <= w_tiu_next;
            r_unit    <= w_unit_next;
            r_delay   <= w_delay_next;
            r_rt      <= w_rt_next;
            r_done    <= w_done_next;
            r_early   <= w_early_next;
            r_timeout <= w_timeout_next;
            r_led     <= (w_state_next == S_ARMED);
            r_busy    <= (w_state_next != S_IDLE);
        end
    end

    assign led        = r_led;
    assign busy       = r_busy;
    assign done       = r_done;
    assign early      = r_early;
    assign timeout    = r_timeout;
    assign rt         = r_rt;
    assign delay_used = r_delay;

endmodule
